// File: rtl/cpu_controller.sv
// cpu_controller: Moore control FSM for the register-file/ALU datapath and the
// fetch/memory path. One micro-step per clock; the instruction fields only feed
// register selects, the shifter and ALU controls, and the branch decisions.
module cpu_controller #(
  parameter logic [1:0] MNONE  = 2'b00,
  parameter logic [1:0] MREAD  = 2'b01,
  parameter logic [1:0] MWRITE = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        load_ir,
  output logic        load_pc,
  output logic        reset_pc,
  output logic        load_addr,
  output logic        addr_sel,
  output logic [1:0]  mem_cmd,
  output logic        halted
);

  typedef enum logic [4:0] {
    RST, IF1, IF2, UPC, DEC, GETA, GETB, EXEC, WREG, WIMM,
    ADDR, LADR, MRD, WMEM, GETD, PASS, MWR, HALT
  } state_t;

  state_t state, state_next;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;
  logic       is_ldr;
  logic       is_mem;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign is_ldr = (opcode == 3'b011);
  assign is_mem = (opcode == 3'b011) || (opcode == 3'b100);

  // State register; reset forces RST at once, even mid-instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RST;
    else       state <= state_next;
  end

  // Next-state decode and state-driven control outputs.
  always_comb begin
    state_next = state;
    readnum    = 3'b000;
    writenum   = 3'b000;
    write      = 1'b0;
    vsel       = 2'b00;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    shift      = 2'b00;
    ALUop      = 2'b00;
    load_ir    = 1'b0;
    load_pc    = 1'b0;
    reset_pc   = 1'b0;
    load_addr  = 1'b0;
    addr_sel   = 1'b0;
    mem_cmd    = MNONE;
    halted     = 1'b0;
    unique case (state)
      RST: begin
        reset_pc   = 1'b1;
        load_pc    = 1'b1;
        state_next = IF1;
      end
      IF1: begin
        addr_sel   = 1'b1;
        mem_cmd    = MREAD;
        state_next = IF2;
      end
      IF2: begin
        addr_sel   = 1'b1;
        mem_cmd    = MREAD;
        load_ir    = 1'b1;
        state_next = UPC;
      end
      UPC: begin
        load_pc    = 1'b1;
        state_next = DEC;
      end
      DEC: begin
        case (opcode)
          3'b110:  state_next = (op == 2'b10) ? WIMM : ((op == 2'b00) ? GETB : IF1);
          3'b101:  state_next = (op == 2'b11) ? GETB : GETA;
          3'b011,
          3'b100:  state_next = (op == 2'b00) ? GETA : IF1;
          3'b111:  state_next = HALT;
          default: state_next = IF1;
        endcase
      end
      GETA: begin
        readnum    = rn;
        loada      = 1'b1;
        state_next = is_mem ? ADDR : GETB;
      end
      GETB: begin
        readnum    = rm;
        loadb      = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        shift = sh;
        bsel  = 1'b0;
        if (opcode == 3'b110) begin
          asel       = 1'b1;
          ALUop      = 2'b00;
          loadc      = 1'b1;
          state_next = WREG;
        end else if (op == 2'b11) begin
          asel       = 1'b1;
          ALUop      = 2'b11;
          loadc      = 1'b1;
          state_next = WREG;
        end else if (op == 2'b01) begin
          ALUop      = 2'b01;
          loads      = 1'b1;
          state_next = IF1;
        end else begin
          ALUop      = op;
          loadc      = 1'b1;
          state_next = WREG;
        end
      end
      WREG: begin
        write      = 1'b1;
        writenum   = rd;
        vsel       = 2'b11;
        state_next = IF1;
      end
      WIMM: begin
        write      = 1'b1;
        writenum   = rn;
        vsel       = 2'b01;
        state_next = IF1;
      end
      ADDR: begin
        bsel       = 1'b1;
        loadc      = 1'b1;
        state_next = LADR;
      end
      LADR: begin
        load_addr  = 1'b1;
        state_next = is_ldr ? MRD : GETD;
      end
      MRD: begin
        mem_cmd    = MREAD;
        state_next = WMEM;
      end
      WMEM: begin
        mem_cmd    = MREAD;
        vsel       = 2'b00;
        write      = 1'b1;
        writenum   = rd;
        state_next = IF1;
      end
      GETD: begin
        readnum    = rd;
        loadb      = 1'b1;
        state_next = PASS;
      end
      PASS: begin
        asel       = 1'b1;
        loadc      = 1'b1;
        state_next = MWR;
      end
      MWR: begin
        mem_cmd    = MWRITE;
        state_next = IF1;
      end
      HALT: begin
        halted     = 1'b1;
        state_next = HALT;
      end
      default: state_next = RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: table-driven, hand-written and random instruction runs
// against a micro-step script built from each instruction's class.
module tb_cpu_controller;

  typedef struct packed {
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] shift;
    logic [1:0] alu_op;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       halted;
  } out_t;

  typedef struct {
    logic [15:0] ir;
    int          cycles;
    logic        wr;
    logic [2:0]  wnum;
    logic [1:0]  vsel;
    logic        memw;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [15:0] ir;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, shift, alu_op, mem_cmd;
  logic        load_ir, load_pc, reset_pc, load_addr, addr_sel, halted;
  out_t        act;
  out_t        exp_q[$];
  int          checks;
  int          errors;

  cpu_controller dut (
    .clk(clk), .reset(reset), .ir(ir),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(alu_op),
    .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
    .load_addr(load_addr), .addr_sel(addr_sel), .mem_cmd(mem_cmd),
    .halted(halted)
  );

  assign act = {readnum, writenum, write, vsel, loada, loadb, loadc, loads,
                asel, bsel, shift, alu_op, load_ir, load_pc, reset_pc,
                load_addr, addr_sel, mem_cmd, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t rst_vec();
    out_t o;
    o = '0;
    o.reset_pc = 1'b1;
    o.load_pc  = 1'b1;
    return o;
  endfunction

  function automatic out_t if1_vec();
    out_t o;
    o = '0;
    o.addr_sel = 1'b1;
    o.mem_cmd  = 2'b01;
    return o;
  endfunction

  // Expected micro-steps of one instruction, starting at the first fetch cycle.
  function automatic void build_script(input logic [15:0] i);
    out_t       o;
    logic [2:0] opc;
    logic [1:0] op;
    logic       movi, movr, alu, ldr, str, cmp, mvn;
    opc  = i[15:13];
    op   = i[12:11];
    movi = (opc == 3'b110) && (op == 2'b10);
    movr = (opc == 3'b110) && (op == 2'b00);
    alu  = (opc == 3'b101);
    ldr  = (opc == 3'b011) && (op == 2'b00);
    str  = (opc == 3'b100) && (op == 2'b00);
    cmp  = alu && (op == 2'b01);
    mvn  = alu && (op == 2'b11);
    exp_q.delete();
    o = if1_vec();        exp_q.push_back(o);
    o.load_ir = 1'b1;     exp_q.push_back(o);
    o = '0; o.load_pc = 1'b1; exp_q.push_back(o);
    o = '0;               exp_q.push_back(o);
    if (movi) begin
      o = '0; o.write = 1'b1; o.writenum = i[10:8]; o.vsel = 2'b01; exp_q.push_back(o);
    end else if (movr || alu) begin
      if (alu && !mvn) begin
        o = '0; o.readnum = i[10:8]; o.loada = 1'b1; exp_q.push_back(o);
      end
      o = '0; o.readnum = i[2:0]; o.loadb = 1'b1; exp_q.push_back(o);
      o = '0; o.shift = i[4:3]; o.asel = movr || mvn;
      o.alu_op = movr ? 2'b00 : op;
      o.loads = cmp; o.loadc = !cmp; exp_q.push_back(o);
      if (!cmp) begin
        o = '0; o.write = 1'b1; o.writenum = i[7:5]; o.vsel = 2'b11; exp_q.push_back(o);
      end
    end else if (ldr || str) begin
      o = '0; o.readnum = i[10:8]; o.loada = 1'b1; exp_q.push_back(o);
      o = '0; o.bsel = 1'b1; o.loadc = 1'b1; exp_q.push_back(o);
      o = '0; o.load_addr = 1'b1; exp_q.push_back(o);
      if (ldr) begin
        o = '0; o.mem_cmd = 2'b01; exp_q.push_back(o);
        o.write = 1'b1; o.writenum = i[7:5]; exp_q.push_back(o);
      end else begin
        o = '0; o.readnum = i[7:5]; o.loadb = 1'b1; exp_q.push_back(o);
        o = '0; o.asel = 1'b1; o.loadc = 1'b1; exp_q.push_back(o);
        o = '0; o.mem_cmd = 2'b10; exp_q.push_back(o);
      end
    end
  endfunction

  task automatic applyStimulus(input logic [15:0] instr);
    ir = instr;
  endtask

  task automatic checkOutput(input string name, input out_t expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Walks one instruction step by step; entered and left at an IF1 negedge.
  task automatic run_script(input logic [15:0] instr, input string tag);
    build_script(instr);
    applyStimulus(instr);
    for (int k = 0; k < exp_q.size(); k++) begin
      checkOutput($sformatf("%s step%0d", tag, k), exp_q[k]);
      @(negedge clk);
    end
  endtask

  vec_t        vecs[10];
  int          cyc;
  logic        saw_wr, saw_mw;
  logic [2:0]  wnum;
  logic [1:0]  wvs;
  logic [15:0] r;
  out_t        o;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    ir     = 16'h0000;
    vecs[0] = '{16'hD105, 5,  1'b1, 3'd1, 2'b01, 1'b0};
    vecs[1] = '{16'hA2E9, 8,  1'b1, 3'd7, 2'b11, 1'b0};
    vecs[2] = '{16'hA902, 7,  1'b0, 3'd0, 2'b00, 1'b0};
    vecs[3] = '{16'h6041, 9,  1'b1, 3'd2, 2'b00, 1'b0};
    vecs[4] = '{16'h8041, 10, 1'b0, 3'd0, 2'b00, 1'b1};
    vecs[5] = '{16'hC0E3, 7,  1'b1, 3'd7, 2'b11, 1'b0};
    vecs[6] = '{16'hB8A4, 7,  1'b1, 3'd5, 2'b11, 1'b0};
    vecs[7] = '{16'hB360, 8,  1'b1, 3'd3, 2'b11, 1'b0};
    vecs[8] = '{16'h0000, 4,  1'b0, 3'd0, 2'b00, 1'b0};
    vecs[9] = '{16'hC800, 4,  1'b0, 3'd0, 2'b00, 1'b0};

    @(negedge clk);
    checkOutput("reset state", rst_vec());
    reset = 1'b0;
    @(negedge clk);
    checkOutput("first IF1", if1_vec());

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].ir);
      cyc = 0; saw_wr = 1'b0; saw_mw = 1'b0; wnum = 3'd0; wvs = 2'b00;
      do begin
        if (write) begin saw_wr = 1'b1; wnum = writenum; wvs = vsel; end
        if (mem_cmd == 2'b10) saw_mw = 1'b1;
        @(negedge clk);
        cyc++;
      end while (!(addr_sel && mem_cmd == 2'b01 && !load_ir) && cyc < 40);
      checkValue($sformatf("cycles ir=%h", vecs[v].ir), cyc, vecs[v].cycles);
      checkValue($sformatf("writeback ir=%h", vecs[v].ir),
                 {26'd0, saw_wr, wnum, wvs}, {26'd0, vecs[v].wr, vecs[v].wnum, vecs[v].vsel});
      checkValue($sformatf("memwrite ir=%h", vecs[v].ir), saw_mw, vecs[v].memw);
    end

    run_script(16'hD105, "MOV imm");
    run_script(16'hA2E9, "ADD");
    run_script(16'hA902, "CMP");
    run_script(16'h6041, "LDR");
    run_script(16'h8041, "STR");

    applyStimulus(16'hA2E9);
    repeat (5) @(negedge clk);
    o = '0; o.readnum = 3'd1; o.loadb = 1'b1;
    checkOutput("GETB before reset", o);
    reset = 1'b1;
    #1;
    checkOutput("async reset in GETB", rst_vec());
    @(negedge clk);
    checkOutput("reset held", rst_vec());
    reset = 1'b0;
    @(negedge clk);
    checkOutput("IF1 after reset", if1_vec());

    for (int n = 0; n < 150; n++) begin
      r = 16'($urandom);
      r[15:13] = 3'($urandom_range(0, 6));
      run_script(r, $sformatf("rand%0d ir=%h", n, r));
    end

    run_script(16'hE000, "HALT fetch");
    o = '0; o.halted = 1'b1;
    for (int n = 0; n < 20; n++) begin
      checkOutput($sformatf("halted cycle%0d", n), o);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    checkOutput("reset from HALT", rst_vec());
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("IF1 after HALT reset", if1_vec());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
